// File: rtl/connect4_pkg.sv
// Shared Connect 4 constants, cell encoding, scan FSM/direction types and the
// direction-to-step helper used by the win/draw checker.
package connect4_pkg;

   localparam int FILAS    = 6;
   localparam int COLUMNAS = 7;
   localparam int EN_LINEA = 4;

   localparam logic [1:0] VACIO = 2'd0;
   localparam logic [1:0] J1    = 2'd1;
   localparam logic [1:0] J2    = 2'd2;

   typedef enum logic [1:0] {IDLE, POS, NEG, DONE} estado_t;
   typedef enum logic [1:0] {H, V, D1, D2} dir_t;

   typedef struct packed {
      logic signed [3:0] d_fila;
      logic signed [3:0] d_col;
   } delta_t;

   function automatic delta_t delta(input dir_t d);
      delta_t r;
      r.d_fila = 4'sd1;
      r.d_col  = 4'sd0;
      case (d)
         H:       begin r.d_fila = 4'sd0; r.d_col = 4'sd1;  end
         V:       begin r.d_fila = 4'sd1; r.d_col = 4'sd0;  end
         D1:      begin r.d_fila = 4'sd1; r.d_col = 4'sd1;  end
         default: begin r.d_fila = 4'sd1; r.d_col = -4'sd1; end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/detector_ganador.sv
// Sequential Connect 4 win/draw checker: walks the four lines through a new piece,
// one board cell per cycle. Define EMPATE_EN to enable the move counter and draw flag.
module detector_ganador
   import connect4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] mov_fila,
   input  logic [2:0] mov_col,
   input  logic [1:0] jugador,
   output logic [2:0] rd_fila,
   output logic [2:0] rd_col,
   input  logic [1:0] rd_dato,
   output logic       busy,
   output logic       done,
   output logic       hay_ganador,
   output logic [1:0] jugador_ganador,
   output logic       empate
);

   estado_t    estado_q, estado_d;
   dir_t       dir_q, dir_d;
   logic [2:0] k_q, k_d;
   logic [2:0] cuenta_q, cuenta_d;
   logic [2:0] org_fila_q, org_fila_d;
   logic [2:0] org_col_q, org_col_d;
   logic [1:0] jug_q, jug_d;
   logic       hay_ganador_q, hay_ganador_d;
   logic [1:0] jug_gan_q, jug_gan_d;
`ifdef EMPATE_EN
   logic [5:0] jugadas_q, jugadas_d;
   logic       empate_q, empate_d;
`endif

   delta_t            dl;
   logic signed [3:0] k_s, off_f, off_c, cel_f, cel_c;
   logic              escaneando, en_tablero, coincide, mov_valido, acepta;
   logic [2:0]        cuenta_inc;

   // Coordinates are 4-bit signed so cells past either edge show up as negative.
   always_comb begin
      dl         = delta(dir_q);
      k_s        = $signed({1'b0, k_q});
      off_f      = k_s * dl.d_fila;
      off_c      = k_s * dl.d_col;
      escaneando = (estado_q == POS) || (estado_q == NEG);
      if (estado_q == NEG) begin
         cel_f = $signed({1'b0, org_fila_q}) - off_f;
         cel_c = $signed({1'b0, org_col_q}) - off_c;
      end else begin
         cel_f = $signed({1'b0, org_fila_q}) + off_f;
         cel_c = $signed({1'b0, org_col_q}) + off_c;
      end
      en_tablero = !cel_f[3] && (cel_f[2:0] < 3'(FILAS)) &&
                   !cel_c[3] && (cel_c[2:0] < 3'(COLUMNAS));
      coincide   = escaneando && en_tablero && (rd_dato != VACIO) && (rd_dato == jug_q);
      cuenta_inc = (cuenta_q >= 3'(EN_LINEA)) ? cuenta_q : cuenta_q + 3'd1;
      mov_valido = ((jugador == J1) || (jugador == J2)) &&
                   (mov_fila < 3'(FILAS)) && (mov_col < 3'(COLUMNAS));
   end

   // Off-board cells are never presented to the board RAM; the origin is shown instead.
   assign rd_fila = (escaneando && en_tablero) ? cel_f[2:0] : org_fila_q;
   assign rd_col  = (escaneando && en_tablero) ? cel_c[2:0] : org_col_q;

   assign busy            = (estado_q != IDLE);
   assign done            = (estado_q == DONE);
   assign hay_ganador     = hay_ganador_q;
   assign jugador_ganador = jug_gan_q;
`ifdef EMPATE_EN
   assign empate = empate_q;
`else
   assign empate = 1'b0;
`endif

   assign acepta = start && !busy && !hay_ganador_q && !empate;

   always_comb begin
      estado_d      = estado_q;
      dir_d         = dir_q;
      k_d           = k_q;
      cuenta_d      = cuenta_q;
      org_fila_d    = org_fila_q;
      org_col_d     = org_col_q;
      jug_d         = jug_q;
      hay_ganador_d = hay_ganador_q;
      jug_gan_d     = jug_gan_q;
`ifdef EMPATE_EN
      jugadas_d     = jugadas_q;
      empate_d      = empate_q;
`endif
      case (estado_q)
         IDLE: begin
            if (acepta) begin
               if (mov_valido) begin
                  estado_d   = POS;
                  org_fila_d = mov_fila;
                  org_col_d  = mov_col;
                  jug_d      = jugador;
                  cuenta_d   = 3'd1;
                  k_d        = 3'd1;
                  dir_d      = H;
`ifdef EMPATE_EN
                  jugadas_d  = jugadas_q + 6'd1;
`endif
               end else begin
                  estado_d = DONE;
               end
            end
         end
         POS, NEG: begin
            if (coincide) begin
               cuenta_d = cuenta_inc;
               k_d      = k_q + 3'd1;
               if (cuenta_inc == 3'(EN_LINEA)) begin
                  estado_d      = DONE;
                  hay_ganador_d = 1'b1;
                  jug_gan_d     = jug_q;
               end
            end else if (estado_q == POS) begin
               k_d      = 3'd1;
               estado_d = NEG;
            end else begin
               cuenta_d = 3'd1;
               k_d      = 3'd1;
               if (dir_q == D2) begin
                  estado_d = DONE;
`ifdef EMPATE_EN
                  if (jugadas_q == 6'(FILAS * COLUMNAS)) empate_d = 1'b1;
`endif
               end else begin
                  dir_d    = dir_t'(dir_q + 2'd1);
                  estado_d = POS;
               end
            end
         end
         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q      <= IDLE;
         dir_q         <= H;
         k_q           <= 3'd0;
         cuenta_q      <= 3'd0;
         org_fila_q    <= 3'd0;
         org_col_q     <= 3'd0;
         jug_q         <= 2'd0;
         hay_ganador_q <= 1'b0;
         jug_gan_q     <= 2'd0;
`ifdef EMPATE_EN
         jugadas_q     <= 6'd0;
         empate_q      <= 1'b0;
`endif
      end else begin
         estado_q      <= estado_d;
         dir_q         <= dir_d;
         k_q           <= k_d;
         cuenta_q      <= cuenta_d;
         org_fila_q    <= org_fila_d;
         org_col_q     <= org_col_d;
         jug_q         <= jug_d;
         hay_ganador_q <= hay_ganador_d;
         jug_gan_q     <= jug_gan_d;
`ifdef EMPATE_EN
         jugadas_q     <= jugadas_d;
         empate_q      <= empate_d;
`endif
      end
   end

endmodule

// File: tb/tb_detector_ganador.sv
// Directed bench for detector_ganador with a behavioural board RAM; expected
// values are hand-computed scan latencies and flag states.
module tb_detector_ganador;
   import connect4_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] mov_fila, mov_col, rd_fila, rd_col;
   logic [1:0] jugador, rd_dato, jugador_ganador;
   logic       busy, done, hay_ganador, empate;

`ifdef EMPATE_EN
   localparam logic EXP_EMPATE = 1'b1;
`else
   localparam logic EXP_EMPATE = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int oob_cnt  = 0;

   logic [1:0] board [0:5][0:6];

   always #5 clk = ~clk;

   detector_ganador dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .mov_fila        (mov_fila),
      .mov_col         (mov_col),
      .jugador         (jugador),
      .rd_fila         (rd_fila),
      .rd_col          (rd_col),
      .rd_dato         (rd_dato),
      .busy            (busy),
      .done            (done),
      .hay_ganador     (hay_ganador),
      .jugador_ganador (jugador_ganador),
      .empate          (empate)
   );

   always_comb begin
      rd_dato = 2'd0;
      if (rd_fila < 3'd6 && rd_col < 3'd7) rd_dato = board[rd_fila][rd_col];
   end

   always @(negedge clk) begin
      if (!rst && (rd_fila >= 3'd6 || rd_col >= 3'd7)) oob_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_board();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            board[r][c] = 2'd0;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
   endtask

   // Called at a negedge; watches 40 cycles for done pulses.
   task automatic move(input int f, input int c, input int j, input int pulse_at,
                       input int rst_at, output int first, output int nd,
                       output int busy_after);
      start    = 1'b1;
      mov_fila = 3'(f);
      mov_col  = 3'(c);
      jugador  = 2'(j);
      @(negedge clk);
      start      = 1'b0;
      first      = 0;
      nd         = 0;
      busy_after = 1;
      for (int n = 1; n <= 40; n++) begin
         if (done === 1'b1) begin
            nd++;
            if (first == 0) first = n;
         end
         if (first != 0 && n == first + 1) busy_after = int'(busy);
         start = (n == pulse_at);
         if (n == pulse_at) begin
            mov_fila = 3'd0;
            mov_col  = 3'd0;
            jugador  = 2'd2;
         end
         rst = (n == rst_at);
         if (n < 40) @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      $display("move f=%0d c=%0d j=%0d: dones=%0d first_done=%0d ganador=%0d/%0d empate=%0d",
               f, c, j, nd, first, hay_ganador, jugador_ganador, empate);
   endtask

   initial begin
      int first, nd, ba, idx;
      start = 1'b0; mov_fila = 3'd0; mov_col = 3'd0; jugador = 2'd0;
      clear_board();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hay", hay_ganador, 0);
      check("rst_jg", jugador_ganador, 0);
      check("rst_empate", empate, 0);
      check("rst_rd", {rd_fila, rd_col}, 0);

      // Horizontal win: J1 at row 0 cols 0..2, new piece at (0,3)
      board[0][0] = J1; board[0][1] = J1; board[0][2] = J1; board[0][3] = J1;
      move(0, 3, 1, 0, 0, first, nd, ba);
      check("h_lat", first, 5);
      check("h_ndone", nd, 1);
      check("h_hay", hay_ganador, 1);
      check("h_jg", jugador_ganador, 1);
      check("h_busy_after", ba, 0);

      // Start after a win is ignored
      move(0, 4, 2, 0, 0, first, nd, ba);
      check("sticky_nodone", nd, 0);
      check("sticky_hay", hay_ganador, 1);

      // Diagonal D2 win for J2
      do_reset();
      clear_board();
      board[0][3] = J2; board[1][2] = J2; board[2][1] = J2; board[3][0] = J2;
      move(3, 0, 2, 0, 0, first, nd, ba);
      check("d2_lat", first, 11);
      check("d2_hay", hay_ganador, 1);
      check("d2_jg", jugador_ganador, 2);
      check("d2_oob", oob_cnt, 0);

      // No win: J1 J1 J1 J2 on row 0, new piece at (0,2)
      do_reset();
      clear_board();
      board[0][0] = J1; board[0][1] = J1; board[0][2] = J1; board[0][3] = J2;
      move(0, 2, 1, 0, 0, first, nd, ba);
      check("nw_lat", first, 11);
      check("nw_hay", hay_ganador, 0);
      check("nw_jg", jugador_ganador, 0);
      check("nw_busy_after", ba, 0);

      // Start while scanning, and start coinciding with DONE, are ignored
      move(0, 2, 1, 3, 0, first, nd, ba);
      check("busy_ndone", nd, 1);
      check("busy_lat", first, 11);
      move(0, 2, 1, 11, 0, first, nd, ba);
      check("donecoll_ndone", nd, 1);

      // Invalid starts: done one cycle later, no flag change
      move(0, 2, 0, 0, 0, first, nd, ba);
      check("inv_j0_lat", first, 1);
      check("inv_j0_ndone", nd, 1);
      move(0, 7, 1, 0, 0, first, nd, ba);
      check("inv_c7_lat", first, 1);
      move(6, 0, 2, 0, 0, first, nd, ba);
      check("inv_f6_lat", first, 1);
      check("inv_hay", hay_ganador, 0);

      // Reset five cycles into a scan
      do_reset();
      clear_board();
      board[0][3] = J2; board[1][2] = J2; board[2][1] = J2; board[3][0] = J2;
      move(3, 0, 2, 0, 5, first, nd, ba);
      check("rstmid_ndone", nd, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_hay", hay_ganador, 0);
      move(3, 0, 2, 0, 0, first, nd, ba);
      check("rstmid_again_lat", first, 11);
      check("rstmid_again_jg", jugador_ganador, 2);

      // Full no-win board, 42 valid starts plus one invalid one
      do_reset();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) begin
            logic [1:0] a;
            a = ((c >> 1) & 1) != 0 ? J2 : J1;
            board[r][c] = (r % 2 == 0) ? a : 2'(3 - a);
         end
      idx = 0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) begin
            move(r, c, int'(board[r][c]), 0, 0, first, nd, ba);
            idx++;
            check("draw_ndone", nd, 1);
            if (idx == 41) check("draw_empate_41", empate, 0);
            if (idx == 20) begin
               move(0, 0, 3, 0, 0, first, nd, ba);
               check("draw_inv_lat", first, 1);
            end
         end
      check("draw_empate_42", empate, EXP_EMPATE);
      check("draw_hay", hay_ganador, 0);
      move(0, 0, 1, 0, 0, first, nd, ba);
      check("draw_after_ndone", nd, EXP_EMPATE ? 0 : 1);
      check("oob_total", oob_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
